branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side 2-bit saturating-counter branch history table (BHT) with a direct-mapped branch target buffer (BTB).
- Consumes the resolved branch outcome produced in EX, the `branch_taken` result of the branch condition logic, and uses it to train its tables.
- Predicts taken/not-taken and the next PC for the current fetch PC.
- Generates the pipeline redirect (flush) request on a mispredict.

Parameters:
- IDX_BITS, 4: table index width. Entries = 2**IDX_BITS. Legal range 1..8.
- TAG_BITS, 30-IDX_BITS: tag width, from pc[31:IDX_BITS+2]. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- if_pc  input  32  fetch PC; word-aligned.
- pred_taken  output  1  prediction for if_pc.
- pred_target  output  32  predicted next PC.
- ex_valid  input  1  conditional branch resolving in EX this cycle.
- ex_pc  input  32  PC of the resolving branch.
- ex_branch_taken  input  1  actual outcome, from branch condition logic.
- ex_target  input  32  actual branch target, pc+imm.
- ex_pred_taken  input  1  prediction carried down the pipe with the branch.
- ex_pred_target  input  32  predicted target carried down the pipe with the branch.
- redirect  output  1  mispredict; flush IF/ID and load redirect_pc.
- redirect_pc  output  32  correct next PC.

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[31:IDX_BITS+2].
- Per entry: valid (1 bit), tag, target (32 bits), ctr (2 bits).
- Reset (async, immediate, including mid-operation): all valid=0, ctr=2'b01, tag=0, target=0.
- Outputs during reset: pred_taken=0, pred_target=if_pc+4, redirect=0, redirect_pc=ex_pc+4.
- Lookup is combinational, zero latency:
  - hit = valid[idx] && tag[idx]==if_tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4.
  - pc+4 wraps modulo 2**32 (0xFFFF_FFFC -> 0x0000_0000).
- Update happens at the rising clk edge when ex_valid=1 and rst=0, indexed by ex_pc:
  - Hit, taken: ctr increments, saturating at 2'b11. target <= ex_target.
  - Hit, not taken: ctr decrements, saturating at 2'b00. target unchanged.
  - Miss, taken: allocate (overwrite any resident entry). valid=1, tag=ex tag, target=ex_target, ctr=2'b10.
  - Miss, not taken: no state change.
- ex_valid=0: no table state changes.
- Mispredict (combinational):
  - redirect = ex_valid && ((ex_branch_taken != ex_pred_taken) || (ex_branch_taken && ex_target != ex_pred_target)).
  - redirect_pc = ex_branch_taken ? ex_target : ex_pc+4.
- Same-index collision (lookup and update to the same index in one cycle): the lookup returns the pre-update entry. No write-to-read bypass.
- Predict/update ordering: prediction is visible from the cycle after the update edge.
- Aliasing: two PCs with equal index and different tag evict each other. A tag mismatch always predicts not-taken.
- Storage is flops (no SRAM). No X may propagate from uninitialised entries.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds three outputs:
  - stat_branches (32): counts cycles with ex_valid=1.
  - stat_mispredicts (32): counts cycles with redirect=1.
  - stat_clr (input, 1): synchronous clear of both counters. clr wins over a simultaneous increment.
- Counters reset to 0 on rst and wrap on overflow.
- When not defined: ports absent, no counter logic, behaviour otherwise identical.

Test Plan:
- After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104. ex_valid=1, ex_pc=0x100, taken=0, pred_taken=0 -> redirect=0; next cycle still pred_taken=0.
- ex_valid=1, ex_pc=0x100, taken=1, ex_target=0x80, pred_taken=0 -> redirect=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1 (ctr=10), pred_target=0x80.
- Train 0x100 taken 3x, then 1x not-taken (pred_taken=1) -> redirect=1, redirect_pc=0x104. Next cycle still pred_taken=1 (ctr 11->10). A second not-taken gives ctr=01 -> pred_taken=0.
- Entry at 0x100 (ctr=10) with IDX_BITS=4; taken branch allocated at 0x140, same index -> 0x100 lookup gives pred_taken=0, 0x140 lookup gives pred_taken=1.
- Correct taken direction but ex_pred_target=0x80 while ex_target=0x90 -> redirect=1, redirect_pc=0x90. Same-cycle lookup of the same PC returns 0x80; next cycle returns 0x90.
- Assert rst mid-stream between clock edges -> pred_taken drops to 0 immediately and all entries miss. Wrap case: if_pc=0xFFFF_FFFC -> pred_target=0x0. With BP_STATS_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit BHT with direct-mapped BTB and EX-stage mispredict redirect.
// Optional BP_STATS_EN adds branch/mispredict event counters with sync clear.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
`ifdef BP_STATS_EN
    input  logic        stat_clr,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [31:0]         target;
        logic [1:0]          ctr;
    } bht_entry_t;

    bht_entry_t tbl [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [TAG_BITS-1:0] ex_tag;
    bht_entry_t          if_ent;
    bht_entry_t          ex_ent;
    bht_entry_t          ex_next;
    logic                if_hit;
    logic                ex_hit;
    logic                ex_wr;
    logic [31:0]         if_pc_seq;
    logic [31:0]         ex_pc_seq;
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[31:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[31:IDX_BITS+2];

    assign if_ent = tbl[if_idx];
    assign ex_ent = tbl[ex_idx];

    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
    assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

    // 32-bit adds wrap naturally at the top of the address space
    assign if_pc_seq = if_pc + 32'd4;
    assign ex_pc_seq = ex_pc + 32'd4;

    // Lookup reads the stored entry only, so a same-cycle update is not bypassed
    assign pred_taken  = !rst && if_hit && if_ent.ctr[1];
    assign pred_target = pred_taken ? if_ent.target : if_pc_seq;

    always_comb begin
        redirect = 1'b0;
        if (!rst && ex_valid) begin
            redirect = (ex_branch_taken != ex_pred_taken) ||
                       (ex_branch_taken && (ex_target != ex_pred_target));
        end
    end

    assign redirect_pc = (!rst && ex_branch_taken) ? ex_target : ex_pc_seq;

    always_comb begin
        ex_next = ex_ent;
        ex_wr   = 1'b0;
        unique case (1'b1)
            ex_hit && ex_branch_taken: begin
                ex_wr          = 1'b1;
                ex_next.target = ex_target;
                if (ex_ent.ctr != 2'b11) begin
                    ex_next.ctr = ex_ent.ctr + 2'b01;
                end
            end
            ex_hit && !ex_branch_taken: begin
                ex_wr = 1'b1;
                if (ex_ent.ctr != 2'b00) begin
                    ex_next.ctr = ex_ent.ctr - 2'b01;
                end
            end
            !ex_hit && ex_branch_taken: begin
                ex_wr   = 1'b1;
                ex_next = '{valid:  1'b1,
                            tag:    ex_tag,
                            target: ex_target,
                            ctr:    2'b10};
            end
            default: begin
                ex_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '{valid:  1'b0,
                            tag:    '0,
                            target: 32'd0,
                            ctr:    2'b01};
            end
        end else if (ex_valid && ex_wr) begin
            tbl[ex_idx] <= ex_next;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (stat_clr) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (ex_valid) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (redirect) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + model-checked bench for branch_predictor.
// Compares every cycle against an associative-array table model.
module tb_branch_predictor;

    localparam int IDX = 4;
    localparam int N   = 1 << IDX;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'd0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.IDX_BITS(IDX)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_branch_taken (ex_branch_taken),
        .ex_target       (ex_target),
        .ex_pred_taken   (ex_pred_taken),
        .ex_pred_target  (ex_pred_target),
`ifdef BP_STATS_EN
        .stat_clr        (stat_clr),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: strength 0..3, taken when >= 2; absent key means invalid entry
    int          m_str [int];
    logic [31:0] m_tag [int];
    logic [31:0] m_tgt [int];
    int          m_br;
    int          m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_str.exists(i) && (m_tag[i] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_str[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_redirect();
        if (rst || !ex_valid) return 1'b0;
        if (ex_branch_taken != ex_pred_taken) return 1'b1;
        return ex_branch_taken && (ex_target != ex_pred_target);
    endfunction

    int  mi;
    bit  mh;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_str.delete();
            m_tag.delete();
            m_tgt.delete();
            m_br  = 0;
            m_mis = 0;
        end else begin
`ifdef BP_STATS_EN
            if (stat_clr) begin
                m_br  = 0;
                m_mis = 0;
            end else begin
                if (ex_valid) m_br++;
                if (m_redirect()) m_mis++;
            end
`endif
            if (ex_valid) begin
                mi = idx_of(ex_pc);
                mh = m_hit(ex_pc);
                if (mh && ex_branch_taken) begin
                    m_str[mi] = (m_str[mi] == 3) ? 3 : m_str[mi] + 1;
                    m_tgt[mi] = ex_target;
                end else if (mh) begin
                    m_str[mi] = (m_str[mi] == 0) ? 0 : m_str[mi] - 1;
                end else if (ex_branch_taken) begin
                    m_str[mi] = 2;
                    m_tag[mi] = tag_of(ex_pc);
                    m_tgt[mi] = ex_target;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_pred_taken", pred_taken, m_pred(if_pc));
        chk("m_pred_target", pred_target, m_target(if_pc));
        chk("m_redirect", redirect, m_redirect());
        chk("m_redirect_pc", redirect_pc,
            (!rst && ex_branch_taken) ? ex_target : ex_pc + 32'd4);
`ifdef BP_STATS_EN
        chk("m_stat_br", stat_branches, m_br);
        chk("m_stat_mis", stat_mispredicts, m_mis);
`endif
    end

    task automatic cyc(input logic [31:0] ipc, input logic v,
                       input logic [31:0] epc, input logic tk,
                       input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt);
        @(posedge clk);
        #1;
        if_pc           = ipc;
        ex_valid        = v;
        ex_pc           = epc;
        ex_branch_taken = tk;
        ex_target       = tgt;
        ex_pred_taken   = ptk;
        ex_pred_target  = ptgt;
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(ipc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    logic [31:0] pcs [5];

    initial begin
        pcs[0] = 32'h100;
        pcs[1] = 32'h140;
        pcs[2] = 32'h104;
        pcs[3] = 32'hFFFF_FFFC;
        pcs[4] = 32'h180;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`ifdef BP_STATS_EN
        #1;
        chk("stat_br_reset", stat_branches, 32'd0);
        chk("stat_mis_reset", stat_mispredicts, 32'd0);
`endif

        cyc(32'h100, 1, 32'h100, 0, 32'h0, 0, 32'h104);
        #1;
        chk("reset_pred", pred_taken, 1'b0);
        chk("reset_tgt", pred_target, 32'h104);
        chk("nt_no_redir", redirect, 1'b0);
        idle(32'h100);
        #1 chk("nt_still_nt", pred_taken, 1'b0);

        cyc(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        #1;
        chk("alloc_redir", redirect, 1'b1);
        chk("alloc_rpc", redirect_pc, 32'h80);
        chk("alloc_pre", pred_taken, 1'b0);
        idle(32'h100);
        #1;
        chk("alloc_pred", pred_taken, 1'b1);
        chk("alloc_tgt", pred_target, 32'h80);

        repeat (3) cyc(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        cyc(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        #1;
        chk("nt_redir", redirect, 1'b1);
        chk("nt_rpc", redirect_pc, 32'h104);
        idle(32'h100);
        #1 chk("ctr10_pred", pred_taken, 1'b1);
        cyc(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        idle(32'h100);
        #1 chk("ctr01_pred", pred_taken, 1'b0);

        cyc(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        idle(32'h100);
        #1 chk("retrain_pred", pred_taken, 1'b1);
        cyc(32'h140, 1, 32'h140, 1, 32'h200, 0, 32'h144);
        idle(32'h100);
        #1 chk("alias_old", pred_taken, 1'b0);
        idle(32'h140);
        #1;
        chk("alias_new", pred_taken, 1'b1);
        chk("alias_tgt", pred_target, 32'h200);

        cyc(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        cyc(32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80);
        #1;
        chk("tgt_redir", redirect, 1'b1);
        chk("tgt_rpc", redirect_pc, 32'h90);
        chk("tgt_same_cyc", pred_target, 32'h80);
        idle(32'h100);
        #1 chk("tgt_next_cyc", pred_target, 32'h90);

        idle(32'hFFFF_FFFC);
        #1 chk("wrap_tgt", pred_target, 32'h0);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] p;
            logic [31:0] q;
            p = pcs[$urandom_range(0, 4)];
            q = pcs[$urandom_range(0, 4)];
            cyc(p, 1'($urandom_range(0, 3) != 0), q,
                1'($urandom_range(0, 1)),
                32'h80 + 32'($urandom_range(0, 3)) * 32'h10,
                ($urandom_range(0, 7) == 0) ? ~m_pred(q) : m_pred(q),
                m_target(q));
        end

        cyc(32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h90);
        cyc(32'h100, 1, 32'h100, 1, 32'hA0, 0, 32'h0);
        #1 chk("pre_rst_redir", redirect, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_pred", pred_taken, 1'b0);
        chk("mid_rst_redir", redirect, 1'b0);
        chk("mid_rst_rpc", redirect_pc, 32'h104);
        @(posedge clk);
        #1 rst = 1'b0;
        ex_valid = 1'b0;
        #1 chk("post_rst_miss", pred_taken, 1'b0);

`ifdef BP_STATS_EN
        cyc(32'h100, 1, 32'h100, 1, 32'hA0, 0, 32'h0);
        idle(32'h100);
        #1;
        chk("stat_br_one", stat_branches, 32'd1);
        chk("stat_mis_one", stat_mispredicts, 32'd1);
        cyc(32'h100, 1, 32'h100, 1, 32'hB0, 1, 32'h0);
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        ex_valid = 1'b0;
        #1;
        chk("stat_br_clr", stat_branches, 32'd0);
        chk("stat_mis_clr", stat_mispredicts, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
